// File: rtl/decodificador_varredura_pkg.sv
// Shared definitions for the scanning one-hot decoder.
//   state_t     : FSM encoding (IDLE / DIRECT / SCAN)
//   MODO_DIRETO : modo value selecting direct decode of a
//   MODO_VARRE  : modo value selecting autonomous scan
package decodificador_varredura_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRETO = 2'd1,
    ST_VARRE  = 2'd2
  } state_t;

  localparam logic MODO_DIRETO = 1'b0;
  localparam logic MODO_VARRE  = 1'b1;

endpackage

// File: rtl/decodificador_varredura_divisor_tick.sv
// Scan-rate prescaler: counts 0..DIV-1 while en_i is high and
// emits tick_o on the cycle the count is at DIV-1 (the count then
// returns to 0). clr_i forces the count to 0 and has priority.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   clr_i  : synchronous clear
//   en_i   : count enable
//   tick_o : high while enabled and count == DIV-1
module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr_i || tick_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decodificador_varredura.sv
// Registered N-to-2^N one-hot decoder with autonomous scan mode.
// DIRECT decodes a (1 clk latency); SCAN walks the active line every
// DIV clocks. Define DECOD_VAI_VOLTA_EN for ping-pong scanning.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   enable : 0 forces y to zero (state IDLE)
//   modo   : 0 = DIRECT, 1 = SCAN
//   a      : select value used in DIRECT
//   y      : registered one-hot output (zero when idle)
//   idx    : registered index of the active line
//   wrap   : one-cycle pulse when the scan wraps / reverses
module decodificador_varredura
  import decodificador_varredura_pkg::*;
#(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            modo,
  input  logic [N-1:0]    a,
  output logic [2**N-1:0] y,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam logic [N-1:0] IDX_MAX = '1;

  state_t          st_q, st_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [2**N-1:0] y_q, y_d;
  logic            wrap_q, wrap_d;
  logic            pre_clr, pre_en, tick;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  // Next state: enable has priority over modo
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: begin
        if (enable) st_d = (modo == MODO_VARRE) ? ST_VARRE : ST_DIRETO;
      end
      ST_DIRETO: begin
        if (!enable)                 st_d = ST_IDLE;
        else if (modo == MODO_VARRE) st_d = ST_VARRE;
      end
      ST_VARRE: begin
        if (!enable)                  st_d = ST_IDLE;
        else if (modo == MODO_DIRETO) st_d = ST_DIRETO;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Prescaler only runs while staying in SCAN; any entry to SCAN
  // starts it from zero so the first step lands DIV clocks later.
  assign pre_clr = (st_q != ST_VARRE) || (st_d != ST_VARRE);
  assign pre_en  = !pre_clr;

  divisor_tick #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pre_clr),
    .en_i   (pre_en),
    .tick_o (tick)
  );

`ifdef DECOD_VAI_VOLTA_EN
  logic dir_q, dir_d;  // 0 = up, 1 = down

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`endif

  // Output/datapath logic, evaluated for the state being entered so
  // the registered outputs line up with that state.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
`ifdef DECOD_VAI_VOLTA_EN
    dir_d  = dir_q;
`endif
    case (st_d)
      ST_DIRETO: idx_d = a;
      ST_VARRE: begin
        if (tick) begin
`ifdef DECOD_VAI_VOLTA_EN
          if (!dir_q) begin
            if (idx_q == IDX_MAX) begin
              dir_d  = 1'b1;
              idx_d  = idx_q - N'(1);
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + N'(1);
            end
          end else begin
            if (idx_q == '0) begin
              dir_d  = 1'b0;
              idx_d  = idx_q + N'(1);
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q - N'(1);
            end
          end
`else
          idx_d  = idx_q + N'(1);
          wrap_d = (idx_q == IDX_MAX);
`endif
        end
      end
      default: ;
    endcase
    y_d = '0;
    if (st_d != ST_IDLE) y_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
